// File: rtl/mem_arbiter_pkg.sv
// Shared widths, requester/state encodings and address helpers for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 32;
  localparam int unsigned VAL_WIDTH_DEF    = 32;
  localparam int unsigned LSB_ID_WIDTH_DEF = 3;
  localparam int unsigned FUNCT3_WIDTH     = 3;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF    = 3;

  // Instruction fetches are always whole words.
  localparam logic [FUNCT3_WIDTH-1:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_LD = 2'd1,
    REQ_ST = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  // Memory-mapped IO lives in the 0x3xxxx window; takes addr[17:16].
  function automatic logic is_io_addr(input logic [1:0] addr_hi);
    return addr_hi == 2'b11;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: eligibility mask, store>load>fetch, starvation override.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                 if_req,
  input  logic                 ld_req,
  input  logic                 st_req,
  input  logic                 flush,
  input  logic                 io_full,
  input  logic                 st_io,
  input  logic [CNT_WIDTH-1:0] starve_cnt,
  output logic                 grant_valid,
  output logic [1:0]           grant_id
);

  logic if_ok;
  logic ld_ok;
  logic st_ok;

  // Mask out ineligible requesters, then pick the winner.
  always_comb begin
    if_ok       = if_req && !flush;
    ld_ok       = ld_req && !flush;
    st_ok       = st_req && !(io_full && st_io);
    grant_valid = if_ok || ld_ok || st_ok;
    grant_id    = REQ_IF;
    if (if_ok && (starve_cnt >= CNT_WIDTH'(STARVE_LIMIT))) begin
      grant_id = REQ_IF;
    end else if (st_ok) begin
      grant_id = REQ_ST;
    end else if (ld_ok) begin
      grant_id = REQ_LD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/load/store onto the single memory controller port, one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned VAL_WIDTH    = VAL_WIDTH_DEF,
  parameter int unsigned LSB_ID_WIDTH = LSB_ID_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_done,
  output logic [VAL_WIDTH-1:0]    if_data,
  input  logic                    ld_req,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [2:0]              ld_type,
  input  logic [LSB_ID_WIDTH-1:0] ld_id,
  output logic                    ld_done,
  output logic [LSB_ID_WIDTH-1:0] ld_id_out,
  output logic [VAL_WIDTH-1:0]    ld_data,
  input  logic                    st_req,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [2:0]              st_type,
  input  logic [VAL_WIDTH-1:0]    st_data,
  output logic                    st_done,
  output logic                    mc_start,
  output logic                    mc_rw,
  output logic [ADDR_WIDTH-1:0]   mc_addr,
  output logic [2:0]              mc_type,
  output logic [VAL_WIDTH-1:0]    mc_wdata,
  input  logic                    mc_done,
  input  logic [VAL_WIDTH-1:0]    mc_rdata,
  output logic                    busy
);

  arb_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    kill_q, kill_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [LSB_ID_WIDTH-1:0] ld_id_q, ld_id_d;
  logic                    mc_start_q, mc_start_d;
  logic                    mc_rw_q, mc_rw_d;
  logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d;
  logic [2:0]              mc_type_q, mc_type_d;
  logic [VAL_WIDTH-1:0]    mc_wdata_q, mc_wdata_d;
  logic                    if_done_q, if_done_d;
  logic [VAL_WIDTH-1:0]    if_data_q, if_data_d;
  logic                    ld_done_q, ld_done_d;
  logic [VAL_WIDTH-1:0]    ld_data_q, ld_data_d;
  logic [LSB_ID_WIDTH-1:0] ld_id_out_q, ld_id_out_d;
  logic                    st_done_q, st_done_d;
  logic                    busy_q, busy_d;
  logic                    kill_now;
  logic                    grant_valid;
  logic [1:0]              grant_id;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pick (
    .if_req     (if_req),
    .ld_req     (ld_req),
    .st_req     (st_req),
    .flush      (flush),
    .io_full    (io_buffer_full),
    .st_io      (is_io_addr(st_addr[17:16])),
    .starve_cnt (cnt_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Next-state, payload latching, starvation counting and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    gnt_d       = gnt_q;
    ld_id_d     = ld_id_q;
    mc_start_d  = mc_start_q;
    mc_rw_d     = mc_rw_q;
    mc_addr_d   = mc_addr_q;
    mc_type_d   = mc_type_q;
    mc_wdata_d  = mc_wdata_q;
    if_done_d   = if_done_q;
    if_data_d   = if_data_q;
    ld_done_d   = ld_done_q;
    ld_data_d   = ld_data_q;
    ld_id_out_d = ld_id_out_q;
    st_done_d   = st_done_q;
    // Stores are never squashed; fetch/load die on any flush after grant.
    kill_now    = kill_q || (flush && (gnt_q != REQ_ST));

    if (rdy_in) begin
      if_done_d   = 1'b0;
      if_data_d   = '0;
      ld_done_d   = 1'b0;
      ld_data_d   = '0;
      ld_id_out_d = '0;
      st_done_d   = 1'b0;
      if (!if_req) begin
        cnt_d = '0;
      end

      case (state_q)
        S_IDLE: begin
          kill_d = 1'b0;
          if (grant_valid) begin
            state_d    = S_ISSUE;
            mc_start_d = 1'b1;
            gnt_d      = grant_id;
            if (grant_id == REQ_IF) begin
              cnt_d = '0;
            end else if (if_req && (cnt_q < CNT_WIDTH'(STARVE_LIMIT))) begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            case (grant_id)
              REQ_ST: begin
                mc_rw_d    = 1'b1;
                mc_addr_d  = st_addr;
                mc_type_d  = st_type;
                mc_wdata_d = st_data;
              end
              REQ_LD: begin
                mc_rw_d    = 1'b0;
                mc_addr_d  = ld_addr;
                mc_type_d  = ld_type;
                mc_wdata_d = '0;
                ld_id_d    = ld_id;
              end
              default: begin
                mc_rw_d    = 1'b0;
                mc_addr_d  = if_addr;
                mc_type_d  = FETCH_FUNCT3;
                mc_wdata_d = '0;
              end
            endcase
          end
        end
        S_ISSUE: begin
          mc_start_d = 1'b0;
          kill_d     = kill_now;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          kill_d = kill_now;
          if (mc_done) begin
            state_d = S_RESP;
            if (!kill_now) begin
              case (gnt_q)
                REQ_ST: st_done_d = 1'b1;
                REQ_LD: begin
                  ld_done_d   = 1'b1;
                  ld_data_d   = mc_rdata;
                  ld_id_out_d = ld_id_q;
                end
                REQ_IF: begin
                  if_done_d = 1'b1;
                  if_data_d = mc_rdata;
                end
                default: ;
              endcase
            end
          end
        end
        S_RESP: begin
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      gnt_q       <= REQ_IF;
      ld_id_q     <= '0;
      mc_start_q  <= 1'b0;
      mc_rw_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_type_q   <= '0;
      mc_wdata_q  <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      ld_done_q   <= 1'b0;
      ld_data_q   <= '0;
      ld_id_out_q <= '0;
      st_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      gnt_q       <= gnt_d;
      ld_id_q     <= ld_id_d;
      mc_start_q  <= mc_start_d;
      mc_rw_q     <= mc_rw_d;
      mc_addr_q   <= mc_addr_d;
      mc_type_q   <= mc_type_d;
      mc_wdata_q  <= mc_wdata_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      ld_done_q   <= ld_done_d;
      ld_data_q   <= ld_data_d;
      ld_id_out_q <= ld_id_out_d;
      st_done_q   <= st_done_d;
      busy_q      <= busy_d;
    end
  end

  // A pending start is only presented to the controller while enabled.
  assign mc_start  = mc_start_q && rdy_in;
  assign mc_rw     = mc_rw_q;
  assign mc_addr   = mc_addr_q;
  assign mc_type   = mc_type_q;
  assign mc_wdata  = mc_wdata_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign ld_done   = ld_done_q;
  assign ld_data   = ld_data_q;
  assign ld_id_out = ld_id_out_q;
  assign st_done   = st_done_q;
  assign busy      = busy_q;

endmodule
